// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep controller: steps a frequency word from f_start toward
// f_stop with a programmable dwell, in single, sawtooth or triangle mode.
module dds_sweep_ctrl #(
    parameter int unsigned FW_W = 26,
    parameter int unsigned DW_W = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic [1:0]      mode,
    input  logic [FW_W-1:0] f_start,
    input  logic [FW_W-1:0] f_stop,
    input  logic [FW_W-1:0] f_step,
    input  logic [DW_W-1:0] dwell,
    output logic [FW_W-1:0] f_word,
    output logic            f_vld,
    output logic            phase_clr,
    output logic            busy,
    output logic            wrap,
    output logic            done
);

    localparam int unsigned SW_W = FW_W + 1;

    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_SAWTOOTH = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      mode_l;
    logic [FW_W-1:0] f_start_l;
    logic [FW_W-1:0] f_stop_l;
    logic [FW_W-1:0] f_step_l;
    logic [DW_W-1:0] dwell_l;
    logic [DW_W-1:0] cnt;
    logic            rev;
    logic            deg;

    logic            up0_c;
    logic            at_end_c;
    logic            s_up_c;
    logic [FW_W-1:0] tgt_c;
    logic [FW_W-1:0] s_end_c;
    logic [SW_W-1:0] sum_c;
    logic [SW_W-1:0] diff_c;
    logic [FW_W-1:0] nxt_c;
    logic [DW_W-1:0] cnt_rld_c;

    // Next word toward the active endpoint; at an endpoint the step is taken
    // toward the opposite endpoint (used only by the triangle turnaround).
    always_comb begin
        up0_c     = (f_start_l <= f_stop_l);
        tgt_c     = rev ? f_start_l : f_stop_l;
        at_end_c  = (f_word == tgt_c);
        s_up_c    = (up0_c ^ rev) ^ at_end_c;
        s_end_c   = (rev ^ at_end_c) ? f_start_l : f_stop_l;
        sum_c     = {1'b0, f_word} + {1'b0, f_step_l};
        diff_c    = {1'b0, f_word} - {1'b0, f_step_l};
        nxt_c     = f_word;
        if (s_up_c) begin
            if (sum_c[FW_W] || (sum_c[FW_W-1:0] >= s_end_c)) nxt_c = s_end_c;
            else                                            nxt_c = sum_c[FW_W-1:0];
        end else begin
            if (diff_c[FW_W] || (diff_c[FW_W-1:0] <= s_end_c)) nxt_c = s_end_c;
            else                                              nxt_c = diff_c[FW_W-1:0];
        end
        cnt_rld_c = (dwell_l == '0) ? '0 : dwell_l - DW_W'(1);
    end

    // Sweep FSM with registered word, status and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            f_word    <= '0;
            f_vld     <= 1'b0;
            phase_clr <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
            mode_l    <= '0;
            f_start_l <= '0;
            f_stop_l  <= '0;
            f_step_l  <= '0;
            dwell_l   <= '0;
            cnt       <= '0;
            rev       <= 1'b0;
            deg       <= 1'b0;
        end else begin
            f_vld     <= 1'b0;
            phase_clr <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        mode_l    <= (mode == 2'd3) ? MODE_SINGLE : mode;
                        f_start_l <= f_start;
                        f_stop_l  <= f_stop;
                        f_step_l  <= f_step;
                        dwell_l   <= dwell;
                        cnt       <= (dwell == '0) ? '0 : dwell - DW_W'(1);
                        deg       <= (f_step == '0) || (f_start == f_stop);
                        rev       <= 1'b0;
                        f_word    <= f_start;
                        f_vld     <= 1'b1;
                        phase_clr <= 1'b1;
                        busy      <= 1'b1;
                        state     <= DWELL;
                    end
                end
                DWELL, STEP: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - DW_W'(1);
                    end else begin
                        cnt   <= cnt_rld_c;
                        state <= DWELL;
                        if (deg) begin
                            if (mode_l == MODE_SINGLE) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                wrap <= 1'b1;
                            end
                        end else if (at_end_c) begin
                            case (mode_l)
                                MODE_SAWTOOTH: begin
                                    f_word    <= f_start_l;
                                    f_vld     <= 1'b1;
                                    phase_clr <= 1'b1;
                                    wrap      <= 1'b1;
                                end
                                MODE_TRIANGLE: begin
                                    f_word <= nxt_c;
                                    f_vld  <= (nxt_c != f_word);
                                    rev    <= ~rev;
                                    wrap   <= 1'b1;
                                end
                                default: begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            endcase
                        end else begin
                            f_word <= nxt_c;
                            f_vld  <= (nxt_c != f_word);
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl with hand-computed expected sequences.
module tb_dds_sweep_ctrl;

    localparam int unsigned FW_W = 26;
    localparam int unsigned DW_W = 24;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            stop;
    logic [1:0]      mode;
    logic [FW_W-1:0] f_start;
    logic [FW_W-1:0] f_stop;
    logic [FW_W-1:0] f_step;
    logic [DW_W-1:0] dwell;
    logic [FW_W-1:0] f_word;
    logic            f_vld;
    logic            phase_clr;
    logic            busy;
    logic            wrap;
    logic            done;

    int n_cmp = 0;
    int n_err = 0;

    dds_sweep_ctrl #(.FW_W(FW_W), .DW_W(DW_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .f_word    (f_word),
        .f_vld     (f_vld),
        .phase_clr (phase_clr),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int w, input bit v, input bit pc,
                           input bit wr, input bit dn, input bit bs);
        chk({tag, ".f_word"},    32'(f_word),    32'(w));
        chk({tag, ".f_vld"},     32'(f_vld),     32'(v));
        chk({tag, ".phase_clr"}, 32'(phase_clr), 32'(pc));
        chk({tag, ".wrap"},      32'(wrap),      32'(wr));
        chk({tag, ".done"},      32'(done),      32'(dn));
        chk({tag, ".busy"},      32'(busy),      32'(bs));
    endtask

    task automatic cfg(input logic [1:0] m, input int fs, input int fe,
                       input int st, input int dw);
        mode    = m;
        f_start = FW_W'(fs);
        f_stop  = FW_W'(fe);
        f_step  = FW_W'(st);
        dwell   = DW_W'(dw);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int w3[9];
        bit r3[9];
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cfg(2'd0, 0, 0, 0, 0);
        tick();
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        tick();
        chk_out("post_reset", 0, 0, 0, 0, 0, 0);

        // Single up sweep, dwell 3.
        cfg(2'd0, 100, 130, 10, 3);
        do_start();
        for (int i = 0; i < 12; i++) begin
            chk_out($sformatf("single[%0d]", i), 100 + 10 * (i / 3), (i % 3) == 0, i == 0, 0, 0, 1);
            tick();
        end
        chk_out("single_done", 130, 0, 0, 0, 1, 0);
        tick();
        chk_out("single_after", 130, 0, 0, 0, 0, 0);

        // Clamp at the endpoint; a start while busy and input changes are ignored.
        cfg(2'd0, 100, 130, 25, 2);
        do_start();
        for (int i = 0; i < 6; i++) begin
            int w;
            w = (i < 2) ? 100 : (i < 4) ? 125 : 130;
            chk_out($sformatf("clamp[%0d]", i), w, (i % 2) == 0, i == 0, 0, 0, 1);
            if (i == 1) begin
                start   = 1'b1;
                f_start = FW_W'(0);
                f_step  = FW_W'(1);
            end
            tick();
            start = 1'b0;
        end
        chk_out("clamp_done", 130, 0, 0, 0, 1, 0);
        tick();

        // Triangle, starting downward.
        cfg(2'd2, 130, 100, 10, 1);
        w3 = '{130, 120, 110, 100, 110, 120, 130, 120, 110};
        r3 = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
        do_start();
        for (int i = 0; i < 9; i++) begin
            chk_out($sformatf("tri[%0d]", i), w3[i], 1, i == 0, r3[i], 0, 1);
            tick();
        end
        chk_out("tri[9]", 100, 1, 0, 0, 0, 1);
        do_stop();
        chk_out("tri_stop", 100, 0, 0, 0, 0, 0);

        // Sawtooth with dwell 0 (one cycle per word).
        cfg(2'd1, 86, 859, 773, 0);
        do_start();
        for (int i = 0; i < 5; i++) begin
            bit rl;
            rl = (i % 2) == 0;
            chk_out($sformatf("saw[%0d]", i), rl ? 86 : 859, 1, rl, rl && (i > 0), 0, 1);
            tick();
        end
        do_stop();
        chk_out("saw_stop", 859, 0, 0, 0, 0, 0);

        // Abort in the second dwell cycle of 110, then restart at once.
        cfg(2'd0, 100, 130, 10, 3);
        do_start();
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("abort[%0d]", i), (i < 3) ? 100 : 110, (i % 3) == 0, i == 0, 0, 0, 1);
            if (i < 4) tick();
        end
        do_stop();
        chk_out("abort_idle", 110, 0, 0, 0, 0, 0);
        do_start();
        chk_out("restart", 100, 1, 1, 0, 0, 1);
        do_stop();

        // Simultaneous start and stop in idle is ignored.
        cfg(2'd0, 200, 300, 10, 1);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk_out("start_stop", 100, 0, 0, 0, 0, 0);
        tick();
        chk_out("start_stop2", 100, 0, 0, 0, 0, 0);

        // Mode 3 behaves as single; f_step 0 gives one word then done.
        cfg(2'd3, 500, 600, 0, 2);
        do_start();
        chk_out("deg0[0]", 500, 1, 1, 0, 0, 1);
        tick();
        chk_out("deg0[1]", 500, 0, 0, 0, 0, 1);
        tick();
        chk_out("deg0_done", 500, 0, 0, 0, 1, 0);
        tick();

        // Equal endpoints in sawtooth: hold forever, wrap per dwell.
        cfg(2'd1, 77, 77, 5, 1);
        do_start();
        chk_out("deg1[0]", 77, 1, 1, 0, 0, 1);
        tick();
        chk_out("deg1[1]", 77, 0, 0, 1, 0, 1);
        tick();
        chk_out("deg1[2]", 77, 0, 0, 1, 0, 1);
        do_stop();

        // Asynchronous reset mid-sweep clears everything immediately.
        cfg(2'd2, 10, 50, 10, 1);
        do_start();
        tick();
        chk_out("pre_rst", 20, 1, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0, 0, 0);
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("post_rst[%0d]", i), 0, 0, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 The module SHALL have parameter FW_W, default 26, giving the frequency word width.
REQ-002 The module SHALL have parameter DW_W, default 24, giving the dwell counter width.
REQ-003 Port clk  input  1  system clock; all logic rising-edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  one-cycle sweep start request.
REQ-006 Port stop  input  1  one-cycle abort request.
REQ-007 Port mode  input  2  sweep mode: 0 single, 1 sawtooth repeat, 2 triangle repeat, 3 treated as 0.
REQ-008 Port f_start  input  FW_W  first frequency word.
REQ-009 Port f_stop  input  FW_W  end frequency word.
REQ-010 Port f_step  input  FW_W  step magnitude.
REQ-011 Port dwell  input  DW_W  hold cycles per word; 0 treated as 1.
REQ-012 Port f_word  output  FW_W  frequency word driven to the DDS phase accumulator.
REQ-013 Port f_vld  output  1  one-cycle pulse on every f_word change.
REQ-014 Port phase_clr  output  1  one-cycle pulse requesting DDS accumulator clear.
REQ-015 Port busy  output  1  high while a sweep is active.
REQ-016 Port wrap  output  1  one-cycle pulse at each endpoint turnaround in modes 1/2.
REQ-017 Port done  output  1  one-cycle pulse on single-sweep completion.

Function
REQ-018 The FSM SHALL have states IDLE, DWELL and STEP; busy = (state != IDLE).
REQ-019 A start in IDLE SHALL latch mode, f_start, f_stop, f_step and dwell; inputs changing mid-sweep are ignored.
REQ-020 On the start edge (cycle N), f_word SHALL equal f_start, with f_vld=1 and phase_clr=1 for cycle N+1, and state SHALL be DWELL.
REQ-021 Direction SHALL be up if latched f_start <= f_stop, otherwise down.
REQ-022 Each word SHALL be held for exactly max(dwell,1) cycles in DWELL, then the FSM goes to STEP for 0 extra cycles (next word visible in the cycle after the last dwell cycle).
REQ-023 Up step: next = cur + f_step, computed at FW_W+1 bits; if carry or next >= endpoint, then next = endpoint (clamp).
REQ-024 Down step: next = cur - f_step; if borrow or next <= endpoint, then next = endpoint (clamp).
REQ-025 After the dwell at the endpoint in mode 0, the FSM SHALL return to IDLE with a done pulse; f_word holds the endpoint.
REQ-026 In mode 1, after the endpoint dwell, f_word SHALL reload f_start with f_vld, phase_clr and wrap pulses.
REQ-027 In mode 2, after the endpoint dwell, the endpoints SHALL swap and the direction reverse, with a wrap pulse; the endpoint is not repeated.
REQ-028 f_step=0 or f_start==f_stop SHALL make f_start the only word: mode 0 gives done after one dwell; modes 1/2 hold indefinitely with a wrap pulse per dwell.
REQ-029 stop in any non-IDLE state SHALL force IDLE next cycle; f_word holds; no done pulse.
REQ-030 start while busy SHALL be ignored; simultaneous start and stop in IDLE SHALL be ignored (stop wins).
REQ-031 f_vld SHALL NOT pulse when a step yields the same word value.

Reset
REQ-032 While rst_n=0: state=IDLE, f_word=0, f_vld=0, phase_clr=0, busy=0, wrap=0, done=0, and the dwell counter and latched config are cleared.
REQ-033 Reset asserted mid-sweep SHALL abort immediately; after release, no output pulses occur until the next start.

Verification
REQ-034 Mode 0, f_start=100, f_stop=130, f_step=10, dwell=3 -> f_word 100,110,120,130, each held 3 cycles; done one cycle after the last 130 cycle; busy=0.
REQ-035 Clamp: f_start=100, f_stop=130, f_step=25, dwell=2 -> 100,125,130; done; never 150.
REQ-036 Down sweep, mode 2: f_start=130, f_stop=100, f_step=10, dwell=1 -> 130,120,110,100,110,120,130,120...; wrap pulses at 100 and at 130.
REQ-037 Mode 1, 86->859, f_step=773, dwell=0 -> 86,859,86,859...; each word held 1 cycle; phase_clr and wrap pulse at each 86 reload.
REQ-038 stop asserted in the 2nd dwell cycle of 110 (REQ-034 config) -> IDLE next cycle, f_word=110 held, no done; a new start is accepted the following cycle.
REQ-039 start and stop asserted together in IDLE, and rst_n pulsed low mid-sweep -> no state change in the first case; all outputs go to 0 immediately in the second.
